fsm_11011_tx: RTL and testbench

FSM_11011_TX -- requirements
Module: fsm_11011_tx

---
 rtl/fsm_11011_tx.sv | 125 ++++++++++++
 tb/tb_fsm_11011_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fsm_11011_tx.sv
// Serial framer: sync 11011, DATA_W payload bits MSB first, optional even parity, GAP_BITS zero guard bits.
// First bit on dout one clk after accept; in_ready only in IDLE, so in_valid while busy is ignored.
module fsm_11011_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              done,
  output logic [2:0]        present_state
);

  localparam int MAX_SD  = (DATA_W > 5) ? DATA_W : 5;
  localparam int CNT_MAX = (GAP_BITS > MAX_SD) ? GAP_BITS : MAX_SD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [4:0] SYNC_PAT = 5'b11011;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SYNC = 3'b001,
    DATA = 3'b010,
    PAR  = 3'b011,
    GAP  = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_sh;
  logic [4:0]        sync_sh;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  // state_q/cn_q name the bit dout will carry after the next edge, so the
  // frame's last bit leaves in the same cycle the FSM is already in GAP/IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dout_d  = 1'b0;
    done_d  = 1'b0;
    sync_sh = SYNC_PAT << cnt_q;
    data_sh = data_q << cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SYNC;
          cnt_d   = CNT_W'(1);
          data_d  = in_data;
          dout_d  = SYNC_PAT[4];
        end
      end
      SYNC: begin
        dout_d = sync_sh[4];
        if (cnt_q == CNT_W'(4)) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        dout_d = data_sh[DATA_W-1];
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PAR;
          end else begin
            done_d  = 1'b1;
            state_d = (GAP_BITS > 0) ? GAP : IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PAR: begin
        dout_d  = ^data_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = (GAP_BITS > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_BITS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign dout          = dout_q;
  assign done          = done_q;
  assign present_state = state_q;

endmodule

// File: tb/tb_fsm_11011_tx.sv
// Directed bench for fsm_11011_tx: default instance plus a no-parity, no-gap streaming instance.
module tb_fsm_11011_tx;

  logic       clk = 1'b0;
  logic       clear;
  logic       in_valid, in_ready, dout, busy, done;
  logic [7:0] in_data;
  logic [2:0] present_state;
  logic       in_valid2, in_ready2, dout2, busy2, done2;
  logic [7:0] in_data2;
  logic [2:0] present_state2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_11011_tx dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dout(dout), .busy(busy), .done(done),
    .present_state(present_state)
  );

  fsm_11011_tx #(.DATA_W(8), .PARITY_EN(0), .GAP_BITS(0)) dut2 (
    .clk(clk), .clear(clear), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .dout(dout2), .busy(busy2), .done(done2),
    .present_state(present_state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid2 = 1'b0; in_data2 = 8'h00;
    tick(); tick();
    checks++; if (present_state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", present_state); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (present_state2 !== 3'b000) begin errors++; $display("FAIL reset_state2: got %b expected 000", present_state2); end
    // clear and in_valid together: clear wins, nothing accepted
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    tick();
    checks++; if (present_state !== 3'b000) begin errors++; $display("FAIL clear_prio_state: got %b expected 000", present_state); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL clear_prio_dout: got %b expected 0", dout); end
    clear = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (present_state !== 3'b000) begin errors++; $display("FAIL clear_prio_after: got %b expected 000", present_state); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (present_state !== 3'b000 || dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc %0d: state=%b dout=%b busy=%b done=%b expected 000/0/0/0",
                 i, present_state, dout, busy, done);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] d, input logic [13:0] exp, input string name);
    logic exp_done;
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0; in_data = ~d;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      exp_done = (i == 13);
      checks++; if (dout !== exp[13-i]) begin errors++; $display("FAIL %s bit%0d dout: got %b expected %b", name, i, dout, exp[13-i]); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL %s bit%0d done: got %b expected %b", name, i, done, exp_done); end
      if (i < 13) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++; $display("FAIL %s bit%0d busy/in_ready: got %b/%b expected 1/0", name, i, busy, in_ready);
        end
      end
    end
    tick();
    checks++; if (dout !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s gap0: dout=%b done=%b busy=%b expected 0/0/1", name, dout, done, busy);
    end
    tick();
    checks++; if (dout !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s gap1: dout=%b done=%b expected 0/0", name, dout, done);
    end
    tick();
    checks++; if (in_ready !== 1'b1 || dout !== 1'b0 || present_state !== 3'b000) begin
      errors++; $display("FAIL %s end: in_ready=%b dout=%b state=%b expected 1/0/000", name, in_ready, dout, present_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
    int ndone;
    exp1 = 16'b11011_00111100_0_00;
    exp2 = 16'b11011_11000011_0_00;
    ndone = 0;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_data = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      if (done === 1'b1) ndone++;
      checks++; if (dout !== exp1[15-i]) begin errors++; $display("FAIL b2b f1 bit%0d: got %b expected %b", i, dout, exp1[15-i]); end
    end
    tick();
    in_valid = 1'b0;
    checks++; if (present_state !== 3'b001) begin errors++; $display("FAIL b2b second accept state: got %b expected 001", present_state); end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      if (done === 1'b1) ndone++;
      checks++; if (dout !== exp2[15-i]) begin errors++; $display("FAIL b2b f2 bit%0d: got %b expected %b", i, dout, exp2[15-i]); end
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b done count: got %0d expected 2", ndone); end
    tick();
    checks++; if (present_state !== 3'b000) begin errors++; $display("FAIL b2b no third frame: state %b expected 000", present_state); end
  endtask

  task automatic test_clear_midframe();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 7; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midclr done at E+%0d: got %b expected 0", i, done); end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (present_state !== 3'b000) begin errors++; $display("FAIL midclr state: got %b expected 000", present_state); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL midclr dout: got %b expected 0", dout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midclr in_ready: got %b expected 1", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midclr done: got %b expected 0", done); end
    test_frame(8'h07, 14'b11011_00000111_1, "after_clear_07");
  endtask

  task automatic test_stream();
    logic [12:0] pat;
    logic        exp_done;
    pat = 13'b11011_11111111;
    in_valid2 = 1'b1; in_data2 = 8'hFF;
    tick();
    for (int i = 0; i < 39; i++) begin
      if (i > 0) tick();
      exp_done = ((i % 13) == 12);
      checks++; if (dout2 !== pat[12-(i%13)]) begin errors++; $display("FAIL stream bit%0d dout: got %b expected %b", i, dout2, pat[12-(i%13)]); end
      checks++; if (done2 !== exp_done) begin errors++; $display("FAIL stream bit%0d done: got %b expected %b", i, done2, exp_done); end
    end
    in_valid2 = 1'b0;
    tick();
    checks++; if (dout2 !== 1'b0 || present_state2 !== 3'b000) begin
      errors++; $display("FAIL stream stop: dout=%b state=%b expected 0/000", dout2, present_state2);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame(8'hA5, 14'b11011_10100101_0, "frame_a5");
    test_back_to_back();
    test_clear_midframe();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
